regfile_mp: RTL

Parametrised multi-port integer register file for the TinyRisc-V core. It supersedes the fixed 2-read/1-write file with configurable width, depth and port counts, same-cycle write-to-read bypass, and a busy-bit scoreboard. The decoder issues reservations, the ALU and load paths write back, and the ALU source muxes read. It sits between decode/issue and the execute stage.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 55 +++++
 rtl/regfile_mp.sv | 94 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and helpers for the multi-port register file
package regfile_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;
    localparam int ZERO_REG     = 0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits with reserve/clear priority
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEFAULT,
    parameter int NRD  = 2,
    parameter int NWR  = 1,
    parameter int AW   = clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    w_enable,
    input  logic [NWR*AW-1:0] rd_num,
    input  logic              rsv_enable,
    input  logic [AW-1:0]     rsv_num,
    input  logic [NRD*AW-1:0] rs_num,
    output logic [NRD-1:0]    rs_busy,
    output logic [NREG-1:0]   busy_vec
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clears are applied first so a same-cycle reservation keeps the register pending.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NWR; i++) begin
            if (w_enable[i]) begin
                busy_d[rd_num[i*AW +: AW]] = 1'b0;
            end
        end
        if (rsv_enable) begin
            busy_d[rsv_num] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rs_busy = '0;
        for (int j = 0; j < NRD; j++) begin
            rs_busy[j] = busy_q[rs_num[j*AW +: AW]];
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port integer register file with bypass and scoreboard
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREG   = NREG_DEFAULT,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    parameter int AW     = clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs_num,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic [NWR-1:0]      w_enable,
    input  logic [NWR*AW-1:0]   rd_num,
    input  logic [NWR*XLEN-1:0] rd_data,
    input  logic                rsv_enable,
    input  logic [AW-1:0]       rsv_num,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NRD-1:0]  sb_busy;

    // Ascending port order lets the highest-index writer win a conflict.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            regs_d[r] = regs_q[r];
        end
        for (int i = 0; i < NWR; i++) begin
            if (w_enable[i] && (rd_num[i*AW +: AW] != AW'(ZERO_REG))) begin
                regs_d[rd_num[i*AW +: AW]] = rd_data[i*XLEN +: XLEN];
            end
        end
        regs_d[ZERO_REG] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR),
        .AW   (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .w_enable   (w_enable),
        .rd_num     (rd_num),
        .rsv_enable (rsv_enable),
        .rsv_num    (rsv_num),
        .rs_num     (rs_num),
        .rs_busy    (sb_busy),
        .busy_vec   (busy_vec)
    );

    // Reset also masks the bypass so reads show zero for as long as rst is high.
    always_comb begin
        rs_data = '0;
        rs_busy = '0;
        for (int j = 0; j < NRD; j++) begin
            rs_data[j*XLEN +: XLEN] = regs_q[rs_num[j*AW +: AW]];
            rs_busy[j]              = sb_busy[j];
            if (BYPASS != 0) begin
                for (int i = 0; i < NWR; i++) begin
                    if (w_enable[i] && (rd_num[i*AW +: AW] != AW'(ZERO_REG)) &&
                        (rd_num[i*AW +: AW] == rs_num[j*AW +: AW])) begin
                        rs_data[j*XLEN +: XLEN] = rd_data[i*XLEN +: XLEN];
                        rs_busy[j]              = 1'b0;
                    end
                end
            end
            if (rst || (rs_num[j*AW +: AW] == AW'(ZERO_REG))) begin
                rs_data[j*XLEN +: XLEN] = '0;
                rs_busy[j]              = 1'b0;
            end
        end
    end

endmodule
